router_out_arbiter: RTL and testbench

- Output-port arbiter and forwarder for the 16x16 router; one instance per output port j.
- Collects bit j of every input-port request vector and grants exactly one input at a time using a round-robin scheme.
- Drives the busy and grant lines back to the input-port FSMs.
- Forwards the granted input's serial payload to the output pins as dout / valido_n / frameo_n.

---
 rtl/router_out_arbiter.sv | 100 ++++++++++
 tb/tb_router_out_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/router_out_arbiter.sv
// router_out_arbiter: round-robin grant of one output port among NPORTS inputs, forwarding the winner's serial payload.
module router_out_arbiter #(
  parameter int NPORTS = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NPORTS-1:0] request16_in,
  input  logic [NPORTS-1:0] data16_in,
  input  logic [NPORTS-1:0] data_enable16_in,
  input  logic [NPORTS-1:0] frame16_n_in,
  output logic [NPORTS-1:0] grant16_out,
  output logic              busy_out,
  output logic              dout,
  output logic              valido_n,
  output logic              frameo_n
);
  localparam int W = NPORTS > 1 ? $clog2(NPORTS) : 1;
  localparam int CW = $clog2(WAIT_MAX + 1);
  typedef enum logic [1:0] {IDLE, GRANT, XFER, RELEASE} state_t;
  state_t state;
  logic [W-1:0] ptr, sel, win;
  logic [CW-1:0] cnt;
  logic req, de;
  assign req = request16_in[sel];
  assign de = data_enable16_in[sel];
  // reverse scan so the last hit is the first set bit at or after ptr
  always_comb begin
    win = '0;
    for (int k = NPORTS - 1; k >= 0; k--)
      if (request16_in[(int'(ptr) + k) % NPORTS]) win = W'((int'(ptr) + k) % NPORTS);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      sel <= '0;
      cnt <= '0;
      grant16_out <= '0;
      busy_out <= 1'b0;
      dout <= 1'b0;
      valido_n <= 1'b1;
      frameo_n <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          grant16_out <= '0;
          busy_out <= 1'b0;
          valido_n <= 1'b1;
          frameo_n <= 1'b1;
          if (|request16_in) begin
            sel <= win;
            grant16_out <= NPORTS'(1) << win;
            busy_out <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!req) begin
            grant16_out <= '0;
            state <= RELEASE;
          end else if (de) begin
            dout <= data16_in[sel];
            valido_n <= 1'b0;
            frameo_n <= frame16_n_in[sel];
            state <= XFER;
          end else if (cnt == CW'(WAIT_MAX - 1)) begin
            grant16_out <= '0;
            state <= RELEASE;
          end else cnt <= cnt + 1'b1;
        end
        XFER: begin
          if (!req) begin
            grant16_out <= '0;
            valido_n <= 1'b1;
            frameo_n <= 1'b1;
            state <= RELEASE;
          end else begin
            dout <= data16_in[sel];
            valido_n <= ~de;
            frameo_n <= de ? frame16_n_in[sel] : 1'b1;
          end
        end
        RELEASE: begin
          busy_out <= 1'b0;
          ptr <= sel == W'(NPORTS - 1) ? '0 : sel + 1'b1;
          cnt <= '0;
          state <= IDLE;
        end
        default: begin
          grant16_out <= '0;
          busy_out <= 1'b0;
          valido_n <= 1'b1;
          frameo_n <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_router_out_arbiter.sv
// tb_router_out_arbiter: cycle vectors with expected outputs, checked through a scoreboard queue.
module tb_router_out_arbiter;
  localparam logic [15:0] F = 16'hFFFF;
  logic clk = 1'b0;
  logic reset;
  logic [15:0] req, data, de, frm, grant;
  logic busy, dout, vn, fn;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  router_out_arbiter #(.NPORTS(16), .WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset), .request16_in(req), .data16_in(data),
    .data_enable16_in(de), .frame16_n_in(frm), .grant16_out(grant),
    .busy_out(busy), .dout(dout), .valido_n(vn), .frameo_n(fn)
  );
  typedef struct {logic rst; logic [15:0] rq, en, d, f, g; logic b, o, vn, fn;} vec_t;
  typedef struct {logic [15:0] g; logic b, o, vn, fn;} exp_t;
  vec_t tbl[$];
  exp_t sb[$];
  task automatic v(input logic r, input logic [15:0] rq, en, d, f, g, input logic b, o, n, fr);
    vec_t x;
    x.rst = r; x.rq = rq; x.en = en; x.d = d; x.f = f; x.g = g; x.b = b; x.o = o; x.vn = n; x.fn = fr;
    tbl.push_back(x);
  endtask
  task automatic apply(input int idx, input vec_t x);
    exp_t e, p;
    @(negedge clk);
    reset = x.rst; req = x.rq; de = x.en; data = x.d; frm = x.f;
    p.g = x.g; p.b = x.b; p.o = x.o; p.vn = x.vn; p.fn = x.fn;
    sb.push_back(p);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if ({grant, busy, dout, vn, fn} !== {e.g, e.b, e.o, e.vn, e.fn}) begin
      errors++;
      $display("FAIL vec%0d got grant=%h busy=%b dout=%b valido_n=%b frameo_n=%b want grant=%h busy=%b dout=%b valido_n=%b frameo_n=%b",
               idx, grant, busy, dout, vn, fn, e.g, e.b, e.o, e.vn, e.fn);
    end
    checks++;
    if (!$onehot0(grant)) begin
      errors++;
      $display("FAIL onehot vec%0d got grant=%h want one-hot or zero", idx, grant);
    end
  endtask
  initial begin
    v(1, 0, 0, 0, F, 0, 0, 0, 1, 1);
    v(1, 0, 0, 0, F, 0, 0, 0, 1, 1);
    // single requester, 4-bit packet
    v(0, 16'h0008, 0, 0, F, 16'h0008, 1, 0, 1, 1);
    v(0, 8, 8, 8, 16'hFFF7, 8, 1, 1, 0, 0);
    v(0, 8, 8, 0, 16'hFFF7, 8, 1, 0, 0, 0);
    v(0, 8, 8, 8, 16'hFFF7, 8, 1, 1, 0, 0);
    v(0, 8, 8, 8, F, 8, 1, 1, 0, 1);
    v(0, 0, 0, 0, F, 0, 1, 1, 1, 1);
    v(0, 0, 0, 0, F, 0, 0, 1, 1, 1);
    v(1, 0, 0, 0, F, 0, 0, 0, 1, 1);
    // round-robin among 2, 5, 15
    v(0, 16'h8024, 0, 0, F, 16'h0004, 1, 0, 1, 1);
    v(0, 16'h8024, 16'h0004, 16'h0004, 16'hFFFB, 16'h0004, 1, 1, 0, 0);
    v(0, 16'h8024, 16'h0004, 0, F, 16'h0004, 1, 0, 0, 1);
    v(0, 16'h8020, 0, 0, F, 0, 1, 0, 1, 1);
    v(0, 16'h8024, 0, 0, F, 0, 0, 0, 1, 1);
    v(0, 16'h8024, 0, 0, F, 16'h0020, 1, 0, 1, 1);
    v(0, 16'h8024, 16'h0020, 16'h0020, 16'hFFDF, 16'h0020, 1, 1, 0, 0);
    v(0, 16'h8024, 16'h0020, 0, F, 16'h0020, 1, 0, 0, 1);
    v(0, 16'h8004, 0, 0, F, 0, 1, 0, 1, 1);
    v(0, 16'h8024, 0, 0, F, 0, 0, 0, 1, 1);
    v(0, 16'h8024, 0, 0, F, 16'h8000, 1, 0, 1, 1);
    v(0, 16'h8024, 16'h8000, 16'h8000, 16'h7FFF, 16'h8000, 1, 1, 0, 0);
    v(0, 16'h8024, 16'h8000, 0, F, 16'h8000, 1, 0, 0, 1);
    v(0, 16'h0024, 0, 0, F, 0, 1, 0, 1, 1);
    v(0, 16'h8024, 0, 0, F, 0, 0, 0, 1, 1);
    v(0, 16'h8024, 0, 0, F, 16'h0004, 1, 0, 1, 1);
    v(0, 16'h8020, 0, 0, F, 0, 1, 0, 1, 1);
    v(0, 0, 0, 0, F, 0, 0, 0, 1, 1);
    // wrap: serve 14, then 0 and 15 contend
    v(0, 16'h4000, 0, 0, F, 16'h4000, 1, 0, 1, 1);
    v(0, 0, 0, 0, F, 0, 1, 0, 1, 1);
    v(0, 16'h8001, 0, 0, F, 0, 0, 0, 1, 1);
    v(0, 16'h8001, 0, 0, F, 16'h8000, 1, 0, 1, 1);
    v(0, 16'h0001, 0, 0, F, 0, 1, 0, 1, 1);
    v(0, 16'h0001, 0, 0, F, 0, 0, 0, 1, 1);
    v(0, 16'h0001, 0, 0, F, 16'h0001, 1, 0, 1, 1);
    // timeout: 15 granted cycles in total
    for (int i = 0; i < 14; i++) v(0, 1, 0, 0, F, 1, 1, 0, 1, 1);
    v(0, 1, 0, 0, F, 0, 1, 0, 1, 1);
    v(0, 1, 0, 0, F, 0, 0, 0, 1, 1);
    v(0, 1, 0, 0, F, 1, 1, 0, 1, 1);
    v(0, 0, 0, 0, F, 0, 1, 0, 1, 1);
    v(0, 0, 0, 0, F, 0, 0, 0, 1, 1);
    // abandon on input 7, then ptr=8 picks 8 over 7
    v(0, 16'h0080, 0, 0, F, 16'h0080, 1, 0, 1, 1);
    v(0, 0, 0, 0, F, 0, 1, 0, 1, 1);
    v(0, 0, 0, 0, F, 0, 0, 0, 1, 1);
    v(0, 16'h0180, 0, 0, F, 16'h0100, 1, 0, 1, 1);
    v(0, 0, 0, 0, F, 0, 1, 0, 1, 1);
    v(0, 0, 0, 0, F, 0, 0, 0, 1, 1);
    // reset during payload bit 3, then ptr=0 picks 0 over 9
    v(0, 1, 0, 0, F, 1, 1, 0, 1, 1);
    v(0, 1, 1, 1, 16'hFFFE, 1, 1, 1, 0, 0);
    v(0, 1, 1, 0, 16'hFFFE, 1, 1, 0, 0, 0);
    v(1, 1, 1, 1, 16'hFFFE, 0, 0, 0, 1, 1);
    v(0, 16'h0201, 0, 0, F, 16'h0001, 1, 0, 1, 1);
    v(0, 0, 0, 0, F, 0, 1, 0, 1, 1);
    v(0, 0, 0, 0, F, 0, 0, 0, 1, 1);
    foreach (tbl[i]) apply(i, tbl[i]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
